pdm_deserializer: RTL
=====================

// Module: pdm_deserializer
// PURPOSE
//  Capture side of the board audio path, the counterpart to the PWM audio serializer.
//  Generates the PDM microphone clock from clock_i and samples the mic's 1-bit data
//  stream. Packs WORD_LENGTH consecutive bits into a word and presents each completed
//  word on data_o with a one-cycle done_o strobe. Feeds the downstream filter/serializer.
// PARAMETERS
//  WORD_LENGTH         16         bits per output word (>=2)
//  SYSTEM_FREQUENCY    100000000  clock_i frequency, Hz
//  SAMPLING_FREQUENCY  2000000    pdm_m_clk_o frequency, Hz
//  CLK_DIV (localparam) SYSTEM_FREQUENCY/(2*SAMPLING_FREQUENCY) = 25 cycles per mic clock
//                       half-period; elaboration error if CLK_DIV < 2
// PORTS
//  clock_i        in   1            system clock, all logic on rising edge
//  reset_n_i      in   1            synchronous reset, active low
//  enable_i       in   1            1 = run mic clock and capture; 0 = idle
//  pdm_m_data_i   in   1            PDM data from microphone (asynchronous)
//  pdm_m_clk_o    out  1            generated microphone clock, registered
//  pdm_lrsel_o    out  1            mic L/R select, constant 0 (data valid on mic clk high)
//  data_o         out  WORD_LENGTH  last completed word, first received bit in MSB
//  done_o         out  1            one-cycle pulse, data_o updated this cycle
// BEHAVIOUR
//  Reset (reset_n_i=0 at a clock edge, overrides enable_i): pdm_m_clk_o=0, done_o=0,
//   data_o=0, divider=0, bit count=0, shift register=0, synchronizer flops=0.
//   pdm_lrsel_o is always 0.
//  Input sync: pdm_m_data_i passes through a 2-flop synchronizer; "sampled bit" below
//   means the synchronizer output (pin value 2 cycles earlier).
//  States: IDLE (enable_i=0) and RUN (enable_i=1); the state equals the registered
//   view of enable_i, with no further FSM.
//  IDLE: divider=0, bit count=0, shift register cleared, pdm_m_clk_o forced 0,
//   done_o=0, data_o holds its last value. Any partial word is discarded.
//  RUN, divider: increments every cycle. On the cycle where divider==CLK_DIV-1:
//   divider->0 and pdm_m_clk_o toggles. The first rising edge of pdm_m_clk_o is
//   registered CLK_DIV cycles after the first enabled edge. Mic clock period is
//   2*CLK_DIV cycles with a 50% duty cycle.
//  RUN, capture: on each high->low toggle of pdm_m_clk_o, the sampled bit shifts
//   into the LSB and prior bits shift left. Bit count increments, range 0..WORD_LENGTH-1.
//  Word complete: the capture that brings bit count to WORD_LENGTH loads data_o with
//   the full shifted word in the same clock edge. done_o=1 for exactly that one cycle.
//   Bit count wraps to 0 and capture continues with no gap, so the word period is
//   WORD_LENGTH*2*CLK_DIV cycles (800 at defaults).
//  Completion and IDLE in the same cycle: if enable_i=0, no completion occurs
//   (IDLE wins) and done_o stays 0.
//  Reset mid-word: same as the reset values above. The first word after reset starts
//   with a fresh bit count.
//  done_o is never asserted on two consecutive cycles.
// TESTING
//  1 Reset: reset_n_i=0 for 3 cycles with enable_i=1 and data=1 -> pdm_m_clk_o=0,
//    done_o=0, data_o=16'h0000, pdm_lrsel_o=0.
//  2 Clock gen: enable_i=1 -> first rise at +25 cycles, toggles every 25 cycles,
//    100 periods measured at exactly 50 cycles each.
//  3 Word capture: drive 16'hA5C3 MSB-first, changing data 5 cycles after each mic
//    clk rise -> data_o=16'hA5C3, single done_o pulse 800 cycles after enable.
//  4 Back-to-back: words 16'hFFFF then 16'h0001 -> done_o pulses exactly 800 cycles
//    apart, data_o=FFFF then 0001, no lost or duplicated bits.
//  5 Enable drop: enable_i=0 after 7 bits -> clk low next cycle, no done_o, data_o
//    holds prior word. Re-enable and send 16'h1234 -> data_o=16'h1234.
//  6 Reset mid-word: reset after 10 bits of 16'hBEEF, then send 16'h0F0F ->
//    data_o=0 after reset, then 16'h0F0F, single done_o pulse.

Source files
------------

// File: rtl/pdm_deserializer_if.sv
// Microphone-side signal bundle for the PDM capture block.
// The slave modport is the deserializer; the master modport is whatever drives and observes it.
interface pdm_deserializer_if #(
   parameter int unsigned WORD_LENGTH = 16
);
   logic                   enable_i;
   logic                   pdm_m_data_i;
   logic                   pdm_m_clk_o;
   logic                   pdm_lrsel_o;
   logic [WORD_LENGTH-1:0] data_o;
   logic                   done_o;

   modport slave (
      input  enable_i,
      input  pdm_m_data_i,
      output pdm_m_clk_o,
      output pdm_lrsel_o,
      output data_o,
      output done_o
   );

   modport master (
      output enable_i,
      output pdm_m_data_i,
      input  pdm_m_clk_o,
      input  pdm_lrsel_o,
      input  data_o,
      input  done_o
   );
endinterface

// File: rtl/pdm_deserializer.sv
// PDM microphone capture: generates the mic clock, synchronizes the data pin and packs
// WORD_LENGTH bits (first bit in MSB) into data_o with a one-cycle done_o strobe.
module pdm_deserializer #(
   parameter int unsigned WORD_LENGTH        = 16,
   parameter int unsigned SYSTEM_FREQUENCY   = 100000000,
   parameter int unsigned SAMPLING_FREQUENCY = 2000000
) (
   input logic              clock_i,
   input logic              reset_n_i,
   pdm_deserializer_if.slave pdm
);
   localparam int unsigned CLK_DIV = SYSTEM_FREQUENCY / (2 * SAMPLING_FREQUENCY);
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned CNT_W   = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

   if (CLK_DIV < 2) begin : g_bad_div
      $error("pdm_deserializer: CLK_DIV must be at least 2");
   end

   typedef enum logic {IDLE, RUN} state_t;

   state_t                 state_q, state_d;
   logic [1:0]             sync_q, sync_d;
   logic [DIV_W-1:0]       div_q, div_d;
   logic                   mclk_q, mclk_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [WORD_LENGTH-1:0] shift_q, shift_d;
   logic [WORD_LENGTH-1:0] data_q, data_d;
   logic                   done_q, done_d;
   logic                   run;

   // Counting starts only once the registered state is RUN, and a low enable_i
   // idles the datapath in the same edge, so a drop beats a coinciding completion.
   always_comb begin
      run     = (state_q == RUN) && pdm.enable_i;
      state_d = pdm.enable_i ? RUN : IDLE;
      sync_d  = {sync_q[0], pdm.pdm_m_data_i};
      div_d   = div_q;
      mclk_d  = mclk_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      data_d  = data_q;
      done_d  = 1'b0;
      if (!run) begin
         div_d   = '0;
         mclk_d  = 1'b0;
         cnt_d   = '0;
         shift_d = '0;
      end else if (div_q == DIV_W'(CLK_DIV - 1)) begin
         div_d  = '0;
         mclk_d = ~mclk_q;
         if (mclk_q) begin
            shift_d = {shift_q[WORD_LENGTH-2:0], sync_q[1]};
            if (cnt_q == CNT_W'(WORD_LENGTH - 1)) begin
               cnt_d  = '0;
               data_d = shift_d;
               done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         sync_q  <= '0;
         div_q   <= '0;
         mclk_q  <= 1'b0;
         cnt_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         div_q   <= div_d;
         mclk_q  <= mclk_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   assign pdm.pdm_m_clk_o = mclk_q;
   assign pdm.pdm_lrsel_o = 1'b0;
   assign pdm.data_o      = data_q;
   assign pdm.done_o      = done_q;
endmodule
